clk_tick_sync: RTL and testbench
================================

CLK_TICK_SYNC -- requirements
Module: clk_tick_sync

Interface
REQ-001 SHALL have parameter INPUT_FREQ_HZ, default 6_000_000, meaning clk_in frequency.
REQ-002 SHALL have parameter EXPECTED_FREQ_HZ, default 60, meaning nominal frequency of slow_clk.
REQ-003 SHALL have parameter TOL_CYCLES, default 1000, meaning allowed period deviation in clk_in cycles.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive in-tolerance periods required to lock.
REQ-005 SHALL have port clk_in, input, 1, sole clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port slow_clk, input, 1, divided clock, asynchronous to clk_in.
REQ-008 SHALL have port tick, output, 1, one-cycle pulse per slow_clk rising edge.
REQ-009 SHALL have port period_cycles, output, CW, last measured tick-to-tick distance.
REQ-010 SHALL have port locked, output, 1, high while slow_clk is stable within tolerance.
REQ-011 SHALL have port timeout, output, 1, one-cycle pulse when no edge arrives within 2*PERIOD.

Function
REQ-012 SHALL derive PERIOD = INPUT_FREQ_HZ/EXPECTED_FREQ_HZ and CW = $clog2(2*PERIOD+1).
REQ-013 SHALL synchronise slow_clk through two flops, then register once more for edge detection.
REQ-014 SHALL assert tick exactly 3 clk_in cycles after the first clk_in edge that samples slow_clk high, for one cycle; falling edges produce nothing.
REQ-015 SHALL run a cycle counter that restarts on each tick and saturates at 2*PERIOD.
REQ-016 SHALL use FSM states SEARCH, MEASURE, LOCKED.
REQ-017 SEARCH: on tick -> MEASURE, counter restarts, period_cycles unchanged.
REQ-018 MEASURE/LOCKED: on tick, period_cycles SHALL load the tick-to-tick distance (ticks N cycles apart -> N).
REQ-019 In-tolerance means |distance - PERIOD| <= TOL_CYCLES, computed unsigned without wrap.
REQ-020 MEASURE: in-tolerance tick increments good count; on reaching LOCK_COUNT -> LOCKED; out-of-tolerance clears good count.
REQ-021 LOCKED: out-of-tolerance tick -> MEASURE, good count cleared, locked drops the next cycle.
REQ-022 locked SHALL be registered and high only in LOCKED.
REQ-023 When counter reaches 2*PERIOD in MEASURE or LOCKED, SHALL pulse timeout one cycle and go to SEARCH, with locked dropping in the same cycle as the timeout pulse; no timeout in SEARCH.
REQ-024 Tick coincident with the saturation cycle SHALL take priority: it is treated as a period measurement, not a timeout.

Reset
REQ-025 rst_n low SHALL immediately clear sync flops, counter, good count, period_cycles=0, tick=0, locked=0, timeout=0, state=SEARCH.
REQ-026 Reset mid-operation SHALL discard any in-progress measurement; first post-reset tick only arms MEASURE.
REQ-027 Sync flops SHALL reset to 0, so slow_clk high at reset release yields no tick until a real rising edge.

Structure
REQ-028 State enum (SEARCH/MEASURE/LOCKED) SHALL live in shared package clk_pkg, alongside default INPUT_FREQ_HZ.
REQ-029 Synchroniser plus edge detector SHALL be sub-module sync_edge (clk_in, rst_n, d, rise).
REQ-030 Counter, tolerance compare and FSM SHALL stay in clk_tick_sync.

Verification (INPUT_FREQ_HZ=1000, EXPECTED_FREQ_HZ=10 -> PERIOD=100, TOL_CYCLES=2, LOCK_COUNT=4)
REQ-031 slow_clk 100-cycle square wave -> tick every 100 cycles, period_cycles=100, locked rises after 5th tick (4 periods).
REQ-032 Locked, one period stretched to 105 -> period_cycles=105, locked falls, re-locks after 4 further good periods.
REQ-033 Locked, slow_clk held low -> timeout pulse 200 cycles after last tick, locked=0, state SEARCH, no further timeout.
REQ-034 Periods 98 and 102 -> treated in-tolerance; 97 -> good count cleared.
REQ-035 rst_n asserted mid-period while locked -> all outputs 0 asynchronously; after release, lock needs 5 fresh ticks.
REQ-036 slow_clk high at reset release -> no tick until next low-to-high transition.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared FSM state encoding and default clock rate for the slow-clock tick synchroniser.
package clk_pkg;

    localparam int unsigned DEFAULT_INPUT_FREQ_HZ = 6_000_000;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus one history flop; emits a registered one-cycle pulse per
// rising edge of d, but only after d has genuinely been seen low since reset.
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;
    logic v1, v2;
    logic armed;

    // NOTE: every flop here uses <= so all stages sample the pre-edge values together;
    // blocking assignments would collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            // The zero reset values of the sync flops are not a real low level, so an
            // input already high at release must not look like a rising edge.
            armed <= armed | (v2 & ~s2);
            rise  <= armed & s2 & ~s3;
        end
    end

endmodule

// File: rtl/clk_tick_sync.sv
// Turns a slow asynchronous clock into clk_in-domain ticks, measures its period and
// reports lock once LOCK_COUNT consecutive periods fall within tolerance.
module clk_tick_sync
    import clk_pkg::*;
#(
    parameter  int unsigned INPUT_FREQ_HZ    = DEFAULT_INPUT_FREQ_HZ,
    parameter  int unsigned EXPECTED_FREQ_HZ = 60,
    parameter  int unsigned TOL_CYCLES       = 1000,
    parameter  int unsigned LOCK_COUNT       = 4,
    localparam int unsigned PERIOD           = INPUT_FREQ_HZ / EXPECTED_FREQ_HZ,
    localparam int unsigned CW               = $clog2(2 * PERIOD + 1)
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          slow_clk,
    output logic          tick,
    output logic [CW-1:0] period_cycles,
    output logic          locked,
    output logic          timeout
);

    localparam int unsigned GW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] SAT    = CW'(2 * PERIOD);
    localparam logic [CW-1:0] NOM    = CW'(PERIOD);
    localparam logic [GW-1:0] GOOD_N = GW'(LOCK_COUNT);

    logic          rise;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] good;
    logic [CW-1:0] dev;
    logic          in_tol;
    logic          saturated;

    sync_edge u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (slow_clk),
        .rise   (rise)
    );

    // Subtract the smaller from the larger so the deviation never wraps.
    assign dev       = (cnt >= NOM) ? (cnt - NOM) : (NOM - cnt);
    assign in_tol    = (32'(dev) <= TOL_CYCLES);
    assign saturated = (cnt == SAT);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            cnt           <= '0;
            good          <= '0;
            period_cycles <= '0;
            tick          <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            tick    <= rise;
            timeout <= 1'b0;

            // cnt holds the distance to the last tick, so a tick N cycles later sees N.
            if (rise)
                cnt <= CW'(1);
            else if (!saturated)
                cnt <= cnt + 1'b1;

            unique case (state)
                SEARCH: begin
                    if (rise) begin
                        state <= MEASURE;
                        good  <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_cycles <= cnt;
                        if (!in_tol) begin
                            good <= '0;
                        end else if (good + 1'b1 == GOOD_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            good   <= '0;
                        end else begin
                            good <= good + 1'b1;
                        end
                    end else if (saturated) begin
                        state   <= SEARCH;
                        timeout <= 1'b1;
                        good    <= '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_cycles <= cnt;
                        if (!in_tol) begin
                            state  <= MEASURE;
                            locked <= 1'b0;
                            good   <= '0;
                        end
                    end else if (saturated) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        timeout <= 1'b1;
                        good    <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_tick_sync.sv
// Directed bench for clk_tick_sync with PERIOD=100, TOL_CYCLES=2, LOCK_COUNT=4.
module tb_clk_tick_sync;

    localparam int CW = 8;

    logic          clk_in   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          slow_clk = 1'b0;
    logic          tick;
    logic [CW-1:0] period_cycles;
    logic          locked;
    logic          timeout;

    int total = 0;
    int bad   = 0;
    int cyc = 0, tick_cnt = 0, to_cnt = 0, last_tick = 0, prev_tick = 0;

    clk_tick_sync #(
        .INPUT_FREQ_HZ    (1000),
        .EXPECTED_FREQ_HZ (10),
        .TOL_CYCLES       (2),
        .LOCK_COUNT       (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .slow_clk      (slow_clk),
        .tick          (tick),
        .period_cycles (period_cycles),
        .locked        (locked),
        .timeout       (timeout)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (tick) begin
            tick_cnt  <= tick_cnt + 1;
            prev_tick <= last_tick;
            last_tick <= cyc;
        end
        if (timeout) to_cnt <= to_cnt + 1;
    end

    // One slow_clk period of n clk_in cycles, starting with a rising edge at a negedge.
    task automatic run_period(input int n);
        slow_clk = 1'b1;
        repeat (n / 2) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (n - n / 2) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        slow_clk = 1'b1;
        repeat (3) @(negedge clk_in);
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++; if (period_cycles !== 8'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_cycles); end
    endtask

    task automatic test_high_at_release();
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        total++; if (tick_cnt !== 0) begin bad++; $display("FAIL high_release_no_tick: got %0d ticks want 0", tick_cnt); end
        slow_clk = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic test_latency();
        slow_clk = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL latency_early: got %b want 0", tick); end
        @(posedge clk_in); #1;
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL latency_tick: got %b want 1", tick); end
        total++; if (period_cycles !== 8'd0) begin bad++; $display("FAIL arm_period: got %0d want 0", period_cycles); end
        @(posedge clk_in); #1;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_width: got %b want 0", tick); end
        @(negedge clk_in);
        repeat (45) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (50) @(negedge clk_in);
        total++; if (tick_cnt !== 1) begin bad++; $display("FAIL falling_no_tick: got %0d ticks want 1", tick_cnt); end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            run_period(100);
            total++; if (locked !== (i == 3)) begin bad++; $display("FAIL lock_step%0d: got %b want %b", i, locked, i == 3); end
            total++; if (period_cycles !== 8'd100) begin bad++; $display("FAIL lock_period%0d: got %0d want 100", i, period_cycles); end
        end
        total++; if (last_tick - prev_tick !== 100) begin bad++; $display("FAIL tick_spacing: got %0d want 100", last_tick - prev_tick); end
        total++; if (tick_cnt !== 5) begin bad++; $display("FAIL tick_count: got %0d want 5", tick_cnt); end
    endtask

    task automatic test_stretch();
        run_period(105);
        run_period(100);
        total++; if (period_cycles !== 8'd105) begin bad++; $display("FAIL stretch_period: got %0d want 105", period_cycles); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL stretch_unlock: got %b want 0", locked); end
        for (int i = 0; i < 4; i++) begin
            run_period(100);
            total++; if (locked !== (i == 3)) begin bad++; $display("FAIL relock_step%0d: got %b want %b", i, locked, i == 3); end
        end
    endtask

    task automatic test_tolerance();
        int lens  [13] = '{98, 102, 100, 97, 100, 98, 102, 97, 100, 100, 100, 100, 100};
        int exp_p [13] = '{100, 98, 102, 100, 97, 100, 98, 102, 97, 100, 100, 100, 100};
        bit exp_l [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 13; k++) begin
            run_period(lens[k]);
            total++; if (period_cycles !== 8'(exp_p[k])) begin bad++; $display("FAIL tol_period%0d: got %0d want %0d", k, period_cycles, exp_p[k]); end
            total++; if (locked !== exp_l[k]) begin bad++; $display("FAIL tol_locked%0d: got %b want %b", k, locked, exp_l[k]); end
        end
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        int at = 0;
        bit lk = 1'b1;
        int base;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk_in);
            if (timeout) begin found = 1'b1; at = cyc; lk = locked; end
        end
        total++; if (!found) begin bad++; $display("FAIL timeout_seen: got none within 300 cycles want pulse"); end
        total++; if (at - last_tick !== 200) begin bad++; $display("FAIL timeout_delay: got %0d want 200", at - last_tick); end
        total++; if (lk !== 1'b0) begin bad++; $display("FAIL timeout_locked: got %b want 0", lk); end
        @(negedge clk_in);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_width: got %b want 0", timeout); end
        base = to_cnt;
        repeat (500) @(negedge clk_in);
        total++; if (to_cnt !== base) begin bad++; $display("FAIL search_no_timeout: got %0d extra want 0", to_cnt - base); end
        run_period(101);
        total++; if (period_cycles !== 8'd100) begin bad++; $display("FAIL search_arm_period: got %0d want 100", period_cycles); end
        run_period(101);
        total++; if (period_cycles !== 8'd101) begin bad++; $display("FAIL search_measure: got %0d want 101", period_cycles); end
        repeat (2) run_period(101);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL search_early_lock: got %b want 0", locked); end
        run_period(101);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL search_relock: got %b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        slow_clk = 1'b1;
        repeat (20) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_reset_locked: got %b want 0", locked); end
        total++; if (period_cycles !== 8'd0) begin bad++; $display("FAIL mid_reset_period: got %0d want 0", period_cycles); end
        total++; if ({tick, timeout} !== 2'b00) begin bad++; $display("FAIL mid_reset_pulses: got %b want 00", {tick, timeout}); end
        @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_in);
        run_period(100);
        total++; if (period_cycles !== 8'd0) begin bad++; $display("FAIL post_reset_arm: got %0d want 0", period_cycles); end
        repeat (3) run_period(100);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL post_reset_early: got %b want 0", locked); end
        run_period(100);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL post_reset_lock: got %b want 1", locked); end
    endtask

    task automatic test_saturation();
        int base = to_cnt;
        run_period(200);
        run_period(100);
        total++; if (period_cycles !== 8'd200) begin bad++; $display("FAIL sat_period: got %0d want 200", period_cycles); end
        total++; if (to_cnt !== base) begin bad++; $display("FAIL sat_no_timeout: got %0d pulses want 0", to_cnt - base); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sat_unlock: got %b want 0", locked); end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_high_at_release();
        test_latency();
        test_lock();
        test_stretch();
        test_tolerance();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
